// File: rtl/instr_fetch.sv
// Instruction fetch stage: a PC register, an instruction-memory handshake with
// a one-entry skid buffer behind decode stalls, and a redirect path.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [15:0] imm_field,
   output logic        misalign
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HELD = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        misalign_q, misalign_d;

   logic [31:0] pc_plus4_s;
   logic [31:0] redir_pc_s;

   assign pc_plus4_s = pc_q + 32'd4;
   assign redir_pc_s = {redirect_target[31:2], 2'b00};

   // Next-state and datapath update; redirect outranks stall in every state.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      misalign_d   = 1'b0;

      case (state_q)
         S_REQ: begin
            if (redirect) begin
               pc_d       = redir_pc_s;
               valid_d    = 1'b0;
               misalign_d = |redirect_target[1:0];
               if (imem_ack) begin
                  state_d = S_REQ;
               end else begin
                  // Memory still owes a response to the old address.
                  drop_addr_d = pc_q;
                  state_d     = S_DROP;
               end
            end else if (imem_ack && !stall) begin
               instr_d = imem_rdata;
               pc4_d   = pc_plus4_s;
               valid_d = 1'b1;
               pc_d    = pc_plus4_s;
            end else if (imem_ack && stall) begin
               skid_instr_d = imem_rdata;
               skid_pc4_d   = pc_plus4_s;
               pc_d         = pc_plus4_s;
               state_d      = S_HELD;
            end else if (!stall) begin
               valid_d = 1'b0;
            end else begin
               state_d = S_REQ;
            end
         end
         S_HELD: begin
            if (redirect) begin
               pc_d       = redir_pc_s;
               valid_d    = 1'b0;
               misalign_d = |redirect_target[1:0];
               state_d    = S_REQ;
            end else if (!stall) begin
               instr_d = skid_instr_q;
               pc4_d   = skid_pc4_q;
               valid_d = 1'b1;
               state_d = S_REQ;
            end else begin
               state_d = S_HELD;
            end
         end
         S_DROP: begin
            if (redirect) begin
               pc_d       = redir_pc_s;
               valid_d    = 1'b0;
               misalign_d = |redirect_target[1:0];
            end else begin
               pc_d = pc_q;
            end
            if (imem_ack) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DROP;
            end
         end
         default: begin
            state_d = S_REQ;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         drop_addr_q  <= 32'h0000_0000;
         instr_q      <= 32'h0000_0000;
         pc4_q        <= 32'h0000_0000;
         valid_q      <= 1'b0;
         skid_instr_q <= 32'h0000_0000;
         skid_pc4_q   <= 32'h0000_0000;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         misalign_q   <= misalign_d;
      end
   end

   // Request is gated by rst_n so nothing is issued while reset is held.
   assign imem_req    = rst_n & (state_q != S_HELD);
   assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign imm_field   = instr_q[15:0];
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, reset-in-DROP sequence, then a
// random ack/stall stream checked against a scoreboard queue.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [15:0] imm_field;
   logic        misalign;

   int pass_cnt = 0;
   int total_cnt = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .imm_field(imm_field), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        e_mis;
      logic        chk;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
   } vec_t;

   vec_t vecs[$];
   logic [63:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic st,
                               input logic rd, input logic [31:0] tgt, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid, input logic e_mis,
                               input logic chk, input logic [31:0] e_instr, input logic [31:0] e_pc4);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.stall = st; v.redir = rd; v.tgt = tgt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_mis = e_mis;
      v.chk = chk; v.e_instr = e_instr; v.e_pc4 = e_pc4;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd_c;
      logic [31:0] exp_pc;
      logic [63:0] ent;
      logic        applied_stall;

      rd_c = 32'h2001_FFFF;
      //              ack rdata          st  rd  tgt            req addr           vld mis chk instr          pc4
      vecs.push_back(mk(1'b1, rd_c,          1'b0,1'b0,32'h0,        1'b1,32'h0000_0000,1'b1,1'b0,1'b1,rd_c,          32'h0000_0004));
      vecs.push_back(mk(1'b1, rd_c,          1'b0,1'b0,32'h0,        1'b1,32'h0000_0004,1'b1,1'b0,1'b1,rd_c,          32'h0000_0008));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b1,32'h0000_0008,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b1,32'h0000_0008,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'h0000_1234, 1'b0,1'b0,32'h0,        1'b1,32'h0000_0008,1'b1,1'b0,1'b1,32'h0000_1234, 32'h0000_000C));
      vecs.push_back(mk(1'b1, 32'hAAAA_8001, 1'b0,1'b0,32'h0,        1'b1,32'h0000_000C,1'b1,1'b0,1'b1,32'hAAAA_8001, 32'h0000_0010));
      vecs.push_back(mk(1'b1, 32'hBBBB_7002, 1'b1,1'b0,32'h0,        1'b1,32'h0000_0010,1'b1,1'b0,1'b1,32'hAAAA_8001, 32'h0000_0010));
      vecs.push_back(mk(1'b0, 32'h0,         1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'hAAAA_8001, 32'h0000_0010));
      vecs.push_back(mk(1'b0, 32'h0,         1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'hAAAA_8001, 32'h0000_0010));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'hBBBB_7002, 32'h0000_0014));
      vecs.push_back(mk(1'b1, 32'hCCCC_0003, 1'b0,1'b0,32'h0,        1'b1,32'h0000_0014,1'b1,1'b0,1'b1,32'hCCCC_0003, 32'h0000_0018));
      vecs.push_back(mk(1'b0, 32'h0,         1'b1,1'b1,32'h0000_0103,1'b1,32'h0000_0018,1'b0,1'b1,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b1,32'h0000_0018,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0,1'b0,32'h0,        1'b1,32'h0000_0018,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'hEEEE_0005, 1'b0,1'b0,32'h0,        1'b1,32'h0000_0100,1'b1,1'b0,1'b1,32'hEEEE_0005, 32'h0000_0104));
      vecs.push_back(mk(1'b1, 32'h1111_1111, 1'b0,1'b1,32'hFFFF_FFFC,1'b1,32'h0000_0104,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'hFFFF_0006, 1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b1,1'b0,1'b1,32'hFFFF_0006, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'h2222_0007, 1'b1,1'b0,32'h0,        1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b0, 32'h0,         1'b1,1'b1,32'h0000_0202,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b1, 32'h3333_0008, 1'b0,1'b0,32'h0,        1'b1,32'h0000_0200,1'b1,1'b0,1'b1,32'h3333_0008, 32'h0000_0204));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0300,1'b1,32'h0000_0204,1'b0,1'b0,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0401,1'b1,32'h0000_0204,1'b0,1'b1,1'b0,32'h0,         32'h0));
      vecs.push_back(mk(1'b0, 32'h0,         1'b0,1'b0,32'h0,        1'b1,32'h0000_0204,1'b0,1'b0,1'b0,32'h0,         32'h0));

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      redirect = 1'b0; redirect_target = 32'h0;
      #1;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'h0, if_id_valid}, 32'h0);
      check("rst_misalign", {31'h0, misalign}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; stall = vecs[i].stall;
         redirect = vecs[i].redir; redirect_target = vecs[i].tgt;
         #1;
         check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
         if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         @(posedge clk); #1;
         check($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
         check($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].e_mis});
         if (vecs[i].chk) begin
            check($sformatf("v%0d_pc4", i), if_id_pc4, vecs[i].e_pc4);
            check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
            check($sformatf("v%0d_imm", i), {16'h0, imm_field}, {16'h0, vecs[i].e_instr[15:0]});
         end
         @(negedge clk);
      end

      // Reset while in DROP: outputs clear without any clock edge.
      imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
      rst_n = 1'b0;
      #1;
      check("drop_rst_req", {31'h0, imem_req}, 32'h0);
      check("drop_rst_addr", imem_addr, 32'h0);
      check("drop_rst_pc4", if_id_pc4, 32'h0);
      check("drop_rst_instr", if_id_instr, 32'h0);
      check("drop_rst_valid", {31'h0, if_id_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_req", {31'h0, imem_req}, 32'h1);
      check("rel_addr", imem_addr, 32'h0);

      // Random ack/stall stream; the memory model answers only live requests.
      exp_pc = 32'h0;
      for (int c = 0; c < 400; c++) begin
         if (c < 380) begin
            stall    = ($urandom_range(0, 9) < 3);
            imem_ack = imem_req && ($urandom_range(0, 9) < 7);
         end else begin
            stall    = 1'b0;
            imem_ack = 1'b0;
         end
         imem_rdata = $urandom;
         if (imem_ack) begin
            check("rand_addr", imem_addr, exp_pc);
            sb.push_back({imem_rdata, exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
         end
         applied_stall = stall;
         @(negedge clk);
         if (!applied_stall && if_id_valid) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_valid", {31'h0, if_id_valid}, 32'h0);
            end else begin
               ent = sb.pop_front();
               check("sb_instr", if_id_instr, ent[63:32]);
               check("sb_pc4", if_id_pc4, ent[31:0]);
            end
         end
      end
      check("sb_drained", sb.size(), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
